// File: rtl/cvxif_pkg.sv
// rtl/cvxif_pkg.sv - shared types and encodings for the CV-X-IF offload controller
package cvxif_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_REG,
        ST_WAIT_RES,
        ST_RESP
    } state_t;

    typedef enum logic [1:0] {
        RSP_OK      = 2'b00,
        RSP_REJECT  = 2'b01,
        RSP_TIMEOUT = 2'b10
    } rsp_status_t;

    localparam logic [6:0] OPCODE_CUSTOM = 7'b1111011;

    localparam logic [2:0] FUNCT3_ADD = 3'b000;
    localparam logic [2:0] FUNCT3_SUB = 3'b001;
    localparam logic [2:0] FUNCT3_MUL = 3'b010;
    localparam logic [2:0] FUNCT3_DIV = 3'b011;

endpackage

// File: rtl/cvxif_offload_ctrl_if.sv
// rtl/cvxif_offload_ctrl_if.sv - issue/register/result channels between core-side initiator and coprocessor
interface cvxif_offload_ctrl_if #(
    parameter int XLEN = 32
);
    logic            issue_valid;
    logic            issue_ready;
    logic [XLEN-1:0] issue_req_instr;
    logic            issue_resp_accept;
    logic            issue_resp_writeback;
    logic [1:0]      issue_resp_register_read;

    logic            register_valid;
    logic            register_ready;
    logic [XLEN-1:0] register_rs0;
    logic [XLEN-1:0] register_rs1;
    logic [1:0]      register_rs_valid;

    logic            result_valid;
    logic            result_ready;
    logic [XLEN-1:0] result_data;

    modport master (
        output issue_valid, issue_req_instr,
        input  issue_ready, issue_resp_accept, issue_resp_writeback, issue_resp_register_read,
        output register_valid, register_rs0, register_rs1, register_rs_valid,
        input  register_ready,
        input  result_valid, result_data,
        output result_ready
    );

    modport slave (
        input  issue_valid, issue_req_instr,
        output issue_ready, issue_resp_accept, issue_resp_writeback, issue_resp_register_read,
        input  register_valid, register_rs0, register_rs1, register_rs_valid,
        output register_ready,
        output result_valid, result_data,
        input  result_ready
    );
endinterface

// File: rtl/cvxif_timeout_cnt.sv
// rtl/cvxif_timeout_cnt.sv - clear/enable counter flagging when the result wait has run out
module cvxif_timeout_cnt #(
    parameter int TIMEOUT_W      = 8,
    parameter int TIMEOUT_CYCLES = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    logic [TIMEOUT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + TIMEOUT_W'(1);
        end
    end

    assign expired = (cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/cvxif_offload_ctrl.sv
// rtl/cvxif_offload_ctrl.sv - single-outstanding CV-X-IF initiator: issue, operands, result, completion
module cvxif_offload_ctrl
    import cvxif_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_W      = 8,
    parameter int TIMEOUT_CYCLES = 200
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_instr,
    input  logic [XLEN-1:0] req_rs0,
    input  logic [XLEN-1:0] req_rs1,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic [1:0]      rsp_status,
    output logic            rsp_writeback,
    cvxif_offload_ctrl_if.master cvx
);
    state_t          state, state_nxt;
    logic [XLEN-1:0] instr_q, rs0_q, rs1_q, data_q;
    logic [1:0]      mask_q;
    logic            wb_q;
    rsp_status_t     status_q;
    logic            to_expired;

    cvxif_timeout_cnt #(
        .TIMEOUT_W      (TIMEOUT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (state != ST_WAIT_RES),
        .en      (state == ST_WAIT_RES),
        .expired (to_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (req_valid) state_nxt = ST_ISSUE;
            ST_ISSUE: begin
                if (cvx.issue_ready) begin
                    if (!cvx.issue_resp_accept)                 state_nxt = ST_RESP;
                    else if (cvx.issue_resp_register_read != 2'b00) state_nxt = ST_REG;
                    else                                        state_nxt = ST_WAIT_RES;
                end
            end
            ST_REG:      if (cvx.register_ready) state_nxt = ST_WAIT_RES;
            ST_WAIT_RES: if (cvx.result_valid || to_expired) state_nxt = ST_RESP;
            ST_RESP:     if (rsp_ready) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready          = 1'b0;
        rsp_valid          = 1'b0;
        cvx.issue_valid    = 1'b0;
        cvx.register_valid = 1'b0;
        cvx.result_ready   = 1'b0;
        case (state)
            ST_IDLE:     req_ready          = 1'b1;
            ST_ISSUE:    cvx.issue_valid    = 1'b1;
            ST_REG:      cvx.register_valid = 1'b1;
            ST_WAIT_RES: cvx.result_ready   = 1'b1;
            ST_RESP:     rsp_valid          = 1'b1;
            default:     ;
        endcase
    end

    // A timed-out instruction never writes rd, so its writeback request is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q  <= '0;
            rs0_q    <= '0;
            rs1_q    <= '0;
            data_q   <= '0;
            mask_q   <= 2'b00;
            wb_q     <= 1'b0;
            status_q <= RSP_OK;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        instr_q <= req_instr;
                        rs0_q   <= req_rs0;
                        rs1_q   <= req_rs1;
                    end
                end
                ST_ISSUE: begin
                    if (cvx.issue_ready) begin
                        if (cvx.issue_resp_accept) begin
                            wb_q   <= cvx.issue_resp_writeback;
                            mask_q <= cvx.issue_resp_register_read;
                        end else begin
                            wb_q     <= 1'b0;
                            data_q   <= '0;
                            status_q <= RSP_REJECT;
                        end
                    end
                end
                ST_WAIT_RES: begin
                    if (cvx.result_valid) begin
                        data_q   <= cvx.result_data;
                        status_q <= RSP_OK;
                    end else if (to_expired) begin
                        data_q   <= '0;
                        wb_q     <= 1'b0;
                        status_q <= RSP_TIMEOUT;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cvx.issue_req_instr   = instr_q;
    assign cvx.register_rs0      = rs0_q;
    assign cvx.register_rs1      = rs1_q;
    assign cvx.register_rs_valid = mask_q;
    assign rsp_data              = data_q;
    assign rsp_status            = status_q;
    assign rsp_writeback         = wb_q;
endmodule

// File: tb/tb_cvxif_offload_ctrl.sv
// tb/tb_cvxif_offload_ctrl.sv - scoreboard bench for cvxif_offload_ctrl with a scripted coprocessor stub
module tb_cvxif_offload_ctrl;
    import cvxif_pkg::*;

    localparam int TO = 8;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  status;
        logic        wb;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_instr = '0;
    logic [31:0] req_rs0 = '0;
    logic [31:0] req_rs1 = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_status;
    logic        rsp_writeback;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    cvxif_offload_ctrl_if #(.XLEN(32)) cvx ();

    cvxif_offload_ctrl #(
        .XLEN           (32),
        .TIMEOUT_W      (8),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_instr     (req_instr),
        .req_rs0       (req_rs0),
        .req_rs1       (req_rs1),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_status    (rsp_status),
        .rsp_writeback (rsp_writeback),
        .cvx           (cvx)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Completion monitor: compares every rsp handshake against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) begin
                check("rsp_expected_pending", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("rsp_data", rsp_data, e.data);
                    check("rsp_status", 32'(rsp_status), 32'(e.status));
                    check("rsp_writeback", 32'(rsp_writeback), 32'(e.wb));
                end
            end
        end
    end

    // delay: index of the WAIT_RES cycle in which the stub returns its result (>= TO means never).
    task automatic run_txn(
        input logic [31:0] instr, input logic [31:0] rs0, input logic [31:0] rs1,
        input logic accept, input logic wb, input logic [1:0] mask, input logic [31:0] res,
        input int stall, input int delay, input int hold, input bit rst_reg,
        input logic [31:0] exp_data, input logic [1:0] exp_status, input logic exp_wb);
        int   n_rr;
        exp_t e;
        if (!rst_reg) begin
            e.data = exp_data; e.status = exp_status; e.wb = exp_wb;
            exp_q.push_back(e);
        end
        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_instr = instr; req_rs0 = rs0; req_rs1 = rs1;
        tick();
        req_valid = 1'b0; req_instr = '0; req_rs0 = '0; req_rs1 = '0;
        for (int s = 0; s < stall; s++) begin
            check("issue_valid_stall", 32'(cvx.issue_valid), 32'd1);
            check("issue_instr_stable", cvx.issue_req_instr, instr);
            tick();
        end
        check("issue_valid", 32'(cvx.issue_valid), 32'd1);
        check("issue_instr", cvx.issue_req_instr, instr);
        cvx.issue_ready = 1'b1; cvx.issue_resp_accept = accept;
        cvx.issue_resp_writeback = wb; cvx.issue_resp_register_read = mask;
        tick();
        cvx.issue_ready = 1'b0; cvx.issue_resp_accept = 1'b0;
        cvx.issue_resp_writeback = 1'b0; cvx.issue_resp_register_read = 2'b00;
        if (accept && mask != 2'b00) begin
            check("register_valid", 32'(cvx.register_valid), 32'd1);
            check("register_rs0", cvx.register_rs0, rs0);
            check("register_rs1", cvx.register_rs1, rs1);
            check("register_rs_valid", 32'(cvx.register_rs_valid), 32'(mask));
            if (rst_reg) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                check("rst_req_ready", 32'(req_ready), 32'd1);
                check("rst_register_valid", 32'(cvx.register_valid), 32'd0);
                check("rst_issue_valid", 32'(cvx.issue_valid), 32'd0);
                check("rst_result_ready", 32'(cvx.result_ready), 32'd0);
                check("rst_register_rs0", cvx.register_rs0, 32'd0);
                check("rst_issue_instr", cvx.issue_req_instr, 32'd0);
                check("rst_rs_valid", 32'(cvx.register_rs_valid), 32'd0);
                for (int k = 0; k < 3; k++) begin
                    check("rst_no_rsp", 32'(rsp_valid), 32'd0);
                    tick();
                end
                return;
            end
            cvx.register_ready = 1'b1;
            tick();
            cvx.register_ready = 1'b0;
        end else begin
            check("no_register_valid", 32'(cvx.register_valid), 32'd0);
        end
        if (accept) begin
            n_rr = 0;
            for (int i = 0; i < 20; i++) begin
                if (!cvx.result_ready) break;
                n_rr++;
                if (i == delay) begin
                    cvx.result_valid = 1'b1; cvx.result_data = res;
                    tick();
                    cvx.result_valid = 1'b0; cvx.result_data = '0;
                    break;
                end
                tick();
            end
            check("wait_res_cycles", 32'(n_rr), (delay >= TO) ? 32'(TO) : 32'(delay + 1));
            if (delay >= TO) begin
                cvx.result_valid = 1'b1; cvx.result_data = 32'hDEAD_BEEF;
                check("late_result_ready", 32'(cvx.result_ready), 32'd0);
                tick();
                check("late_result_ready_hold", 32'(cvx.result_ready), 32'd0);
                cvx.result_valid = 1'b0; cvx.result_data = '0;
            end
        end
        check("rsp_valid_prompt", 32'(rsp_valid), 32'd1);
        for (int h = 0; h < hold; h++) begin
            tick();
            check("rsp_valid_hold", 32'(rsp_valid), 32'd1);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("idle_after_rsp", 32'(req_ready), 32'd1);
        check("rsp_valid_dropped", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        cvx.issue_ready = 1'b0; cvx.issue_resp_accept = 1'b0; cvx.issue_resp_writeback = 1'b0;
        cvx.issue_resp_register_read = 2'b00; cvx.register_ready = 1'b0;
        cvx.result_valid = 1'b0; cvx.result_data = '0;
        tick();
        tick();
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_issue_valid", 32'(cvx.issue_valid), 32'd0);
        check("reset_register_valid", 32'(cvx.register_valid), 32'd0);
        check("reset_result_ready", 32'(cvx.result_ready), 32'd0);
        check("reset_rsp_data", rsp_data, 32'd0);
        check("reset_rsp_status", 32'(rsp_status), 32'd0);
        check("reset_issue_instr", cvx.issue_req_instr, 32'd0);
        rst = 1'b0;
        tick();

        // add 1.0 + 1.0 = 2.0, minimum latency
        run_txn(32'h003100FB, 32'h4000, 32'h4000, 1'b1, 1'b1, 2'b11, 32'h5000, 0, 0, 0, 1'b0,
                32'h5000, 2'b00, 1'b1);
        // mul 1.0 * 2.0 = 2.0 with issue_ready held off 3 cycles
        run_txn(32'h003120FB, 32'h4000, 32'h5000, 1'b1, 1'b1, 2'b11, 32'h5000, 3, 0, 0, 1'b0,
                32'h5000, 2'b00, 1'b1);
        // funct7=1 rejected
        run_txn(32'h023100FB, 32'h4000, 32'h4000, 1'b0, 1'b1, 2'b11, 32'h0, 0, 0, 0, 1'b0,
                32'h0, 2'b01, 1'b0);
        // no result ever: timeout, late result ignored
        run_txn(32'h003130FB, 32'h4000, 32'h0000, 1'b1, 1'b1, 2'b11, 32'h0, 0, 255, 0, 1'b0,
                32'h0, 2'b10, 1'b0);
        // result in the final WAIT_RES cycle wins over timeout
        run_txn(32'h003100FB, 32'h4000, 32'h4000, 1'b1, 1'b1, 2'b11, 32'h5000, 0, TO - 1, 0, 1'b0,
                32'h5000, 2'b00, 1'b1);
        // no operands requested: straight to WAIT_RES
        run_txn(32'h003110FB, 32'h1111, 32'h2222, 1'b1, 1'b0, 2'b00, 32'h1234, 1, 2, 0, 1'b0,
                32'h1234, 2'b00, 1'b0);
        // rsp_ready held low 5 cycles, then reset mid-REG on the next transaction
        run_txn(32'h003100FB, 32'h4000, 32'h4000, 1'b1, 1'b1, 2'b11, 32'h5000, 0, 1, 5, 1'b0,
                32'h5000, 2'b00, 1'b1);
        run_txn(32'h003120FB, 32'h4000, 32'h5000, 1'b1, 1'b1, 2'b11, 32'h0, 0, 0, 0, 1'b1,
                32'h0, 2'b00, 1'b0);
        // recovery after reset, rs1 only
        run_txn(32'h003120FB, 32'h4000, 32'h5000, 1'b1, 1'b1, 2'b01, 32'h5000, 0, 0, 0, 1'b0,
                32'h5000, 2'b00, 1'b1);

        tick();
        tick();
        check("rsp_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/cvxif_offload_ctrl.md
Name: cvxif_offload_ctrl

Overview:
Core-side initiator for the CV-X-IF offload interface. It takes one custom instruction plus its operand values from the core pipeline and drives the issue, register and result handshakes toward a coprocessor such as the posit PAU. It then returns the result, or a reject/timeout status, to the core. One instruction is in flight at a time; it sits between the decode/execute stage and any CV-X-IF coprocessor.

Parameters:
XLEN, 32, width of instruction, operands and result
TIMEOUT_W, 8, width of result-wait counter
TIMEOUT_CYCLES, 200, cycles in WAIT_RES before abort (must be < 2^TIMEOUT_W)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  core offers instruction
req_ready  out  1  controller can take instruction
req_instr  in  XLEN  raw instruction word
req_rs0  in  XLEN  rs1 operand value
req_rs1  in  XLEN  rs2 operand value
rsp_valid  out  1  completion available to core
rsp_ready  in  1  core consumes completion
rsp_data  out  XLEN  result value (0 unless status OK)
rsp_status  out  2  00 OK, 01 REJECT, 10 TIMEOUT
rsp_writeback  out  1  coprocessor requested rd writeback
issue_valid  out  1  issue request valid
issue_ready  in  1  coprocessor ready for issue
issue_req_instr  out  XLEN  instruction to coprocessor
issue_resp_accept  in  1  coprocessor accepts; sampled only on issue handshake
issue_resp_writeback  in  1  sampled on issue handshake
issue_resp_register_read  in  2  operand mask; sampled on issue handshake
register_valid  out  1  operands valid
register_ready  in  1  coprocessor takes operands
register_rs0  out  XLEN  operand 0
register_rs1  out  XLEN  operand 1
register_rs_valid  out  2  equals latched register_read mask
result_valid  in  1  coprocessor result valid
result_ready  out  1  controller accepts result
result_data  in  XLEN  coprocessor result

Behaviour:
- Reset: all outputs 0, state IDLE, latched instr/operands/result/status cleared, counter 0. Reset mid-transaction abandons it silently; no rsp is produced.
- Control outputs are Moore (decoded from state only); data outputs come from registers.
- State IDLE:
  - req_ready=1.
  - req_valid latches instr, rs0, rs1 -> ISSUE.
- State ISSUE:
  - issue_valid=1; issue_req_instr = latched instr.
  - issue_valid holds until issue_ready; instr is stable throughout.
  - Handshake with accept=1: latch writeback and mask. Mask != 00 -> REG; mask == 00 -> WAIT_RES.
  - Handshake with accept=0: status=REJECT, data=0, writeback=0 -> RESP.
- State REG:
  - register_valid=1; rs0/rs1/rs_valid stable until register_ready.
  - On handshake: clear counter -> WAIT_RES.
- State WAIT_RES:
  - result_ready=1; counter increments each cycle.
  - result_valid latches result_data, status=OK -> RESP. result_valid wins if it arrives in the same cycle as timeout.
  - Counter == TIMEOUT_CYCLES-1 with no result: status=TIMEOUT, data=0 -> RESP.
  - A late result after timeout is ignored: result_ready is 0 outside WAIT_RES.
- State RESP:
  - rsp_valid=1; data, status and writeback stable.
  - rsp_ready -> IDLE. A new req is accepted no earlier than the cycle after return to IDLE.
- Minimum latency with an always-ready coprocessor: req handshake at cycle 0, issue at 1, register at 2, result at 3, rsp_valid at 4.

Decomposition:
- cvxif_pkg holds:
  - state enum (IDLE, ISSUE, REG, WAIT_RES, RESP)
  - rsp_status codes
  - custom opcode 7'b1111011
  - funct3 codes ADD 000, SUB 001, MUL 010, DIV 011
- One sub-module, cvxif_timeout_cnt: clear/enable/expire counter parameterised by TIMEOUT_W and TIMEOUT_CYCLES.

Test Plan:
- Against the posit PAU (N=16, es=1): req_instr=0x003100FB (add), rs0=0x4000, rs1=0x4000 -> issue accepted with mask 11, rsp_status=00, rsp_data=0x5000, rsp_writeback=1.
- req_instr=0x003120FB (mul), rs0=0x4000, rs1=0x5000 -> rsp_data=0x5000, status 00; issue_req_instr is held stable while issue_ready is deasserted for 3 cycles.
- req_instr=0x023100FB (funct7=1) -> issue handshake with accept=0, no register_valid ever, rsp_status=01, rsp_data=0.
- Stub coprocessor never raises result_valid, TIMEOUT_CYCLES=8 -> rsp_status=10 exactly 8 cycles after the register handshake. A late result_valid is not consumed (result_ready=0).
- rsp_ready held low 5 cycles, then rst pulsed mid-REG on a second transaction -> outputs 0, IDLE with req_ready=1 next cycle, no rsp_valid.
